// File: rtl/fir_pkg.sv
// Shared defaults and types for the FIR tap sequencer: capture state encoding
// and the {first, data} entry carried through the sample skid FIFO.
package fir_pkg;
   localparam int FIR_DWIDTH  = 16;
   localparam int FIR_NTAPS   = 64;
   localparam int FIR_FIFO_AW = 3;

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      CAPTURE    = 1'b1
   } cap_state_e;

   typedef struct packed {
      logic                  first;
      logic [FIR_DWIDTH-1:0] data;
   } fifo_entry_t;
endpackage

// File: rtl/fir_seq_fifo.sv
// Small synchronous FIFO with full/empty flags. The head word is visible
// combinationally so the issue register can load it in the same cycle it pops.
module fir_seq_fifo #(
   parameter int WIDTH   = 17,
   parameter int FIFO_AW = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int DEPTH = 1 << FIFO_AW;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_q];
   assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
endmodule

// File: rtl/fir_tap_sequencer.sv
// Pairs each frame's sample k with coefficient k and issues the pairs to an
// external MAC over valid/ready; forwards the MAC's per-frame result as y.
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter int DWIDTH  = FIR_DWIDTH,
   parameter int NTAPS   = FIR_NTAPS,
   parameter int AWIDTH  = $clog2(NTAPS),
   parameter int FIFO_AW = FIR_FIFO_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic              s_first,
   input  logic [DWIDTH-1:0] s_data,
   input  logic              coef_we,
   input  logic [AWIDTH-1:0] coef_addr,
   input  logic [DWIDTH-1:0] coef_wdata,
   output logic              mac_valid,
   input  logic              mac_ready,
   output logic [DWIDTH-1:0] mac_a,
   output logic [DWIDTH-1:0] mac_b,
   output logic              mac_first,
   output logic              mac_last,
   input  logic              acc_valid,
   input  logic [DWIDTH-1:0] acc_data,
   output logic              y_valid,
   output logic [DWIDTH-1:0] y_data,
   output logic              ovf,
   output logic              ferr,
   output logic              busy
);
   localparam logic [AWIDTH:0]   CAP_FULL = (AWIDTH+1)'(NTAPS);
   localparam logic [AWIDTH:0]   CAP_ONE  = (AWIDTH+1)'(1);
   localparam logic [AWIDTH-1:0] LAST_TAP = AWIDTH'(NTAPS-1);

   logic              s_valid_q, s_first_q;
   logic [DWIDTH-1:0] s_data_q;
   cap_state_e        cap_state_q, cap_state_d;
   logic [AWIDTH:0]   cap_cnt_q, cap_cnt_d;
   logic              ovf_q, ovf_d, ferr_q, ferr_d;
   fifo_entry_t       push_entry, head;
   logic              push_req, push, pop, fifo_full, fifo_empty;
   logic [DWIDTH-1:0] coef_q [NTAPS];
   logic              mac_valid_q, mac_valid_d, mac_first_q, mac_first_d;
   logic              mac_last_q, mac_last_d, in_frame_q, in_frame_d;
   logic [DWIDTH-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
   logic [AWIDTH-1:0] iss_cnt_q, iss_cnt_d;
   logic              load, orphan;
   logic              y_valid_q;
   logic [DWIDTH-1:0] y_data_q;

   // Input stage registered so the capture FSM sees a clean, timed sample stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_valid_q <= 1'b0;
         s_first_q <= 1'b0;
         s_data_q  <= '0;
      end else begin
         s_valid_q <= s_valid;
         s_first_q <= s_first;
         s_data_q  <= s_data;
      end
   end

   always_comb begin
      cap_state_d      = cap_state_q;
      cap_cnt_d        = cap_cnt_q;
      ovf_d            = ovf_q;
      ferr_d           = ferr_q;
      push_req         = 1'b0;
      push_entry.first = 1'b0;
      push_entry.data  = s_data_q;
      if (s_valid_q) begin
         case (cap_state_q)
            WAIT_FIRST: begin
               if (s_first_q) begin
                  push_req         = 1'b1;
                  push_entry.first = 1'b1;
                  cap_cnt_d        = CAP_ONE;
                  cap_state_d      = CAPTURE;
               end
            end
            CAPTURE: begin
               if (s_first_q) begin
                  if (cap_cnt_q != CAP_FULL) ferr_d = 1'b1;
                  push_req         = 1'b1;
                  push_entry.first = 1'b1;
                  cap_cnt_d        = CAP_ONE;
               end else if (cap_cnt_q != CAP_FULL) begin
                  push_req  = 1'b1;
                  cap_cnt_d = cap_cnt_q + CAP_ONE;
               end
            end
            default: ;
         endcase
      end
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push = push_req && (!fifo_full || pop);
      if (push_req && !push) begin
         ovf_d       = 1'b1;
         cap_state_d = WAIT_FIRST;
         cap_cnt_d   = '0;
      end
   end

   fir_seq_fifo #(
      .WIDTH   ($bits(fifo_entry_t)),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (push_entry),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (coef_we) coef_q[coef_addr] <= coef_wdata;
   end

   always_comb begin
      mac_valid_d = mac_valid_q;
      mac_a_d     = mac_a_q;
      mac_b_d     = mac_b_q;
      mac_first_d = mac_first_q;
      mac_last_d  = mac_last_q;
      iss_cnt_d   = iss_cnt_q;
      in_frame_d  = in_frame_q;
      // A continuation entry with no open frame has nothing to pair with.
      orphan      = !fifo_empty && !head.first && !in_frame_q;
      load        = !fifo_empty && !orphan && (!mac_valid_q || mac_ready);
      pop         = orphan || load;
      if (mac_valid_q && mac_ready) mac_valid_d = 1'b0;
      if (load) begin
         iss_cnt_d   = head.first ? '0 : iss_cnt_q + AWIDTH'(1);
         mac_valid_d = 1'b1;
         mac_a_d     = head.data;
         mac_b_d     = coef_q[iss_cnt_d];
         mac_first_d = head.first;
         mac_last_d  = (iss_cnt_d == LAST_TAP);
         in_frame_d  = !mac_last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_state_q <= WAIT_FIRST;
         cap_cnt_q   <= '0;
         ovf_q       <= 1'b0;
         ferr_q      <= 1'b0;
         mac_valid_q <= 1'b0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_first_q <= 1'b0;
         mac_last_q  <= 1'b0;
         iss_cnt_q   <= '0;
         in_frame_q  <= 1'b0;
         y_valid_q   <= 1'b0;
         y_data_q    <= '0;
      end else begin
         cap_state_q <= cap_state_d;
         cap_cnt_q   <= cap_cnt_d;
         ovf_q       <= ovf_d;
         ferr_q      <= ferr_d;
         mac_valid_q <= mac_valid_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         mac_first_q <= mac_first_d;
         mac_last_q  <= mac_last_d;
         iss_cnt_q   <= iss_cnt_d;
         in_frame_q  <= in_frame_d;
         y_valid_q   <= acc_valid;
         if (acc_valid) y_data_q <= acc_data;
      end
   end

   assign mac_valid = mac_valid_q;
   assign mac_a     = mac_a_q;
   assign mac_b     = mac_b_q;
   assign mac_first = mac_first_q;
   assign mac_last  = mac_last_q;
   assign y_valid   = y_valid_q;
   assign y_data    = y_data_q;
   assign ovf       = ovf_q;
   assign ferr      = ferr_q;
   assign busy      = !fifo_empty || mac_valid_q || in_frame_q;
endmodule
